// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern controller.
//   MODE_*      : 2-bit per-channel mode encodings
//   clog2_min1  : ceil(log2(n)) clamped to at least 1, used for index and counter widths
package led_pkg;

   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_ON    = 2'd1;
   localparam logic [1:0] MODE_BLINK = 2'd2;
   localparam logic [1:0] MODE_PWM   = 2'd3;

   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Shared timebase for all LED channels.
//   clk, rst_n  : system clock, async active-low reset
//   sync_clr    : restart prescaler, PWM and blink counters (wins over counting)
//   tick        : registered 1-cycle pulse, one cycle after each internal tick
//   pwm_cnt     : free-running PWM counter, advances once per tick
//   blink_ph    : blink phase, toggles every BLINK_TICKS ticks
module led_tick_gen
   import led_pkg::*;
#(
   parameter int PRESCALE    = 1000,
   parameter int PWM_BITS    = 8,
   parameter int BLINK_TICKS = 256
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sync_clr,
   output logic                tick,
   output logic [PWM_BITS-1:0] pwm_cnt,
   output logic                blink_ph
);

   localparam int PRESC_W = clog2_min1(PRESCALE);
   localparam int BLINK_W = clog2_min1(BLINK_TICKS);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

   logic [PRESC_W-1:0] presc_cnt;
   logic [BLINK_W-1:0] blink_cnt;
   logic               tick_int;

   // With PRESCALE=1 the counter sits at 0 == PRESC_LAST, so every cycle ticks.
   assign tick_int = (presc_cnt == PRESC_LAST) && !sync_clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_cnt <= '0;
         pwm_cnt   <= '0;
         blink_cnt <= '0;
         blink_ph  <= 1'b0;
         tick      <= 1'b0;
      end else if (sync_clr) begin
         presc_cnt <= '0;
         pwm_cnt   <= '0;
         blink_cnt <= '0;
         blink_ph  <= 1'b0;
         tick      <= 1'b0;
      end else begin
         tick      <= tick_int;
         presc_cnt <= tick_int ? '0 : presc_cnt + 1'b1;
         if (tick_int) begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (blink_cnt == BLINK_LAST) begin
               blink_cnt <= '0;
               blink_ph  <= ~blink_ph;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED driver with per-channel mode (OFF/ON/BLINK/PWM) and duty,
// all channels phase-aligned to one shared timebase.
//   clk, rst_n        : system clock, async active-low reset
//   wr_en/wr_ch       : 1-cycle config write strobe and target channel
//   wr_mode/wr_duty   : mode and PWM compare value loaded on a valid write
//   sync_clr          : restart the shared timebase
//   led               : registered LED drive, 1 = lit
//   tick              : registered timebase tick pulse
module led_pattern_ctrl
   import led_pkg::*;
#(
   parameter int   NUM_CH      = 4,
   parameter int   PRESCALE    = 1000,
   parameter int   PWM_BITS    = 8,
   parameter int   BLINK_TICKS = 256,
   localparam int  CH_W        = clog2_min1(NUM_CH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_ch,
   input  logic [1:0]          wr_mode,
   input  logic [PWM_BITS-1:0] wr_duty,
   input  logic                sync_clr,
   output logic [NUM_CH-1:0]   led,
   output logic                tick
);

   logic [1:0]          mode_q [NUM_CH];
   logic [PWM_BITS-1:0] duty_q [NUM_CH];
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                blink_ph;
   logic [NUM_CH-1:0]   led_nxt;

   function automatic logic led_level(input logic [1:0]          mode,
                                      input logic [PWM_BITS-1:0] duty,
                                      input logic [PWM_BITS-1:0] pwm,
                                      input logic                ph);
      case (mode)
         MODE_ON:    return 1'b1;
         MODE_BLINK: return ph;
         MODE_PWM:   return pwm < duty;
         default:    return 1'b0;
      endcase
   endfunction

   led_tick_gen #(
      .PRESCALE    (PRESCALE),
      .PWM_BITS    (PWM_BITS),
      .BLINK_TICKS (BLINK_TICKS)
   ) u_tick_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .sync_clr (sync_clr),
      .tick     (tick),
      .pwm_cnt  (pwm_cnt),
      .blink_ph (blink_ph)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            mode_q[i] <= MODE_OFF;
            duty_q[i] <= '0;
         end
      end else if (wr_en && (int'(wr_ch) < NUM_CH)) begin
         mode_q[wr_ch] <= wr_mode;
         duty_q[wr_ch] <= wr_duty;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign led_nxt[c] = led_level(mode_q[c], duty_q[c], pwm_cnt, blink_ph);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led <= '0;
      end else begin
         led <= led_nxt;
      end
   end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
module tb_led_pattern_ctrl;

   localparam int NUM_CH = 4;
   localparam int P      = 2;
   localparam int PB     = 3;
   localparam int BT     = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic [1:0]    wr_ch = '0;
   logic [1:0]    wr_mode = '0;
   logic [PB-1:0] wr_duty = '0;
   logic          sync_clr = 1'b0;
   logic [NUM_CH-1:0] led;
   logic          tick;

   int checks = 0;
   int failures = 0;

   led_pattern_ctrl #(
      .NUM_CH(NUM_CH), .PRESCALE(P), .PWM_BITS(PB), .BLINK_TICKS(BT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch),
      .wr_mode(wr_mode), .wr_duty(wr_duty), .sync_clr(sync_clr),
      .led(led), .tick(tick)
   );

   always #5 clk = ~clk;

   // Reference model: n = edges since the last timebase restart.
   // ticks elapsed = n / P; pwm = ticks mod 2^PB; phase = (ticks / BT) mod 2.
   int       n = 0;
   int       m_mode [NUM_CH];
   int       m_duty [NUM_CH];
   logic [NUM_CH:0] exp_q [$];

   always @(posedge clk) begin
      logic [NUM_CH:0] e;
      int ticks, pwm, ph;
      if (!rst_n) begin
         exp_q.push_back('0);
         n = 0;
         for (int i = 0; i < NUM_CH; i++) begin
            m_mode[i] = 0;
            m_duty[i] = 0;
         end
      end else begin
         ticks = n / P;
         pwm   = ticks % (1 << PB);
         ph    = (ticks / BT) % 2;
         for (int i = 0; i < NUM_CH; i++) begin
            case (m_mode[i])
               1:       e[i+1] = 1'b1;
               2:       e[i+1] = (ph == 1);
               3:       e[i+1] = (pwm < m_duty[i]);
               default: e[i+1] = 1'b0;
            endcase
         end
         e[0] = ((n % P) == P - 1) && !sync_clr;
         exp_q.push_back(e);
         if (sync_clr) n = 0;
         else          n++;
         if (wr_en && int'(wr_ch) < NUM_CH) begin
            m_mode[wr_ch] = int'(wr_mode);
            m_duty[wr_ch] = int'(wr_duty);
         end
      end
   end

   // Monitor: one registered output set per edge, compared half a cycle later.
   always @(negedge clk) begin
      logic [NUM_CH:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if ({led, tick} !== e) begin
            failures++;
            $display("FAIL out_cmp t=%0t led=%b tick=%b expected led=%b tick=%b",
                     $time, led, tick, e[NUM_CH:1], e[0]);
         end
      end
   end

   task automatic step(input logic we, input logic [1:0] ch, input logic [1:0] md,
                       input logic [PB-1:0] dt, input logic sc);
      @(negedge clk);
      wr_en = we; wr_ch = ch; wr_mode = md; wr_duty = dt; sync_clr = sc;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, 2'd0, 2'd0, '0, 1'b0);
   endtask

   task automatic rand_run(input int cycles);
      for (int i = 0; i < cycles; i++)
         step(($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), PB'($urandom_range(0, 7)),
              ($urandom_range(0, 40) == 0));
   endtask

   task automatic async_reset_check();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (led !== '0 || tick !== 1'b0) begin
         failures++;
         $display("FAIL async_reset led=%b tick=%b expected led=0000 tick=0", led, tick);
      end
      wr_en = 1'b0; sync_clr = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      idle(3);
      // ON / OFF writes
      step(1'b1, 2'd1, 2'd1, 3'd0, 1'b0);
      step(1'b1, 2'd0, 2'd0, 3'd5, 1'b0);
      idle(3);
      // BLINK written together with a timebase restart
      step(1'b1, 2'd2, 2'd2, 3'd0, 1'b1);
      idle(20);
      // PWM duty sweep: 3, 0, 7
      step(1'b1, 2'd3, 2'd3, 3'd3, 1'b1);
      idle(34);
      step(1'b1, 2'd3, 2'd3, 3'd0, 1'b0);
      idle(20);
      step(1'b1, 2'd3, 2'd3, 3'd7, 1'b0);
      idle(34);
      // mid-period restart
      idle(1);
      step(1'b0, 2'd0, 2'd0, 3'd0, 1'b1);
      idle(10);
      // light everything, then reset mid-run
      step(1'b1, 2'd0, 2'd1, 3'd0, 1'b0);
      step(1'b1, 2'd3, 2'd1, 3'd0, 1'b0);
      idle(2);
      async_reset_check();
      idle(5);
      rand_run(1500);
      async_reset_check();
      rand_run(1500);
      idle(2);
      @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached at t=%0t expected finish earlier", $time);
      $fatal(1, "timeout");
   end

endmodule
